// File: rtl/dsram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dsram_arbiter
// Purpose  : Shares the single-port data SRAM between the pipeline Mem1 stage
//            and the external refill/debug port, returning read data to its owner.
// Revision : 1.0
// ============================================================================
module dsram_arbiter #(
    parameter int CACHE_WIDTHE  = 6,
    parameter int CACHE_DEEPTHE = 6,
    parameter int STARVE_LIMIT  = 4,
    localparam int DW = 1 << CACHE_WIDTHE
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     iPipeReq,
    input  logic                     iPipeWrEn,
    input  logic [CACHE_DEEPTHE-1:0] iPipeAddr,
    input  logic [DW-1:0]            iPipeWrData,
    input  logic [DW-1:0]            iPipeWrMask,
    output logic                     oPipeGnt,
    output logic                     oPipeStall,
    output logic                     oPipeRdValid,
    output logic [DW-1:0]            oPipeRdData,

    input  logic                     iExtReq,
    input  logic                     iExtWrEn,
    input  logic [CACHE_DEEPTHE-1:0] iExtAddr,
    input  logic [DW-1:0]            iExtWrData,
    input  logic [DW-1:0]            iExtWrMask,
    output logic                     oExtGnt,
    output logic                     oExtRdValid,
    output logic [DW-1:0]            oExtRdData,

    output logic                     oCen,
    output logic                     oWrEn,
    output logic [CACHE_DEEPTHE-1:0] oAddr,
    output logic [DW-1:0]            oWrData,
    output logic [DW-1:0]            oWrMask,
    input  logic [DW-1:0]            iMemData
);

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PIPE_RD = 2'd1,
        S_EXT_RD  = 2'd2
    } rd_owner_t;

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    rd_owner_t  rd_owner_q;
    rd_owner_t  rd_owner_d;

    logic w_force_ext;
    logic w_ext_gnt;
    logic w_pipe_gnt;

    // The external port normally yields to the pipeline, unless it has
    // waited STARVE_LIMIT consecutive cycles.
    assign w_force_ext = iExtReq & (starve_cnt_q == c_STARVE_LIMIT);
    assign w_ext_gnt   = ~rst & iExtReq & (w_force_ext | ~iPipeReq);
    assign w_pipe_gnt  = ~rst & iPipeReq & ~w_ext_gnt;

    assign oExtGnt    = w_ext_gnt;
    assign oPipeGnt   = w_pipe_gnt;
    assign oPipeStall = iPipeReq & ~w_pipe_gnt;
    assign oCen       = w_pipe_gnt | w_ext_gnt;

    always_comb begin
        oWrEn   = 1'b0;
        oAddr   = '0;
        oWrData = '0;
        oWrMask = '0;
        if (w_ext_gnt) begin
            oWrEn   = iExtWrEn;
            oAddr   = iExtAddr;
            oWrData = iExtWrData;
            oWrMask = iExtWrMask;
        end else if (w_pipe_gnt) begin
            oWrEn   = iPipeWrEn;
            oAddr   = iPipeAddr;
            oWrData = iPipeWrData;
            oWrMask = iPipeWrMask;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!iExtReq || w_ext_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != c_STARVE_LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rd_owner_d = S_IDLE;
        if (w_pipe_gnt && !iPipeWrEn) begin
            rd_owner_d = S_PIPE_RD;
        end else if (w_ext_gnt && !iExtWrEn) begin
            rd_owner_d = S_EXT_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            rd_owner_q   <= S_IDLE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // SRAM read data arrives one cycle after the grant; route it to the owner.
    assign oPipeRdValid = (rd_owner_q == S_PIPE_RD);
    assign oExtRdValid  = (rd_owner_q == S_EXT_RD);
    assign oPipeRdData  = oPipeRdValid ? iMemData : '0;
    assign oExtRdData   = oExtRdValid  ? iMemData : '0;

endmodule
`default_nettype wire

// File: tb/tb_dsram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsram_arbiter
// Purpose  : Directed bench for dsram_arbiter with an SRAM model and a
//            read-return scoreboard.
// Revision : 1.0
// ============================================================================
module tb_dsram_arbiter;

    localparam int AW = 6;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          iPipeReq, iPipeWrEn, iExtReq, iExtWrEn;
    logic [AW-1:0] iPipeAddr, iExtAddr;
    logic [DW-1:0] iPipeWrData, iPipeWrMask, iExtWrData, iExtWrMask;
    logic          oPipeGnt, oPipeStall, oPipeRdValid, oExtGnt, oExtRdValid;
    logic [DW-1:0] oPipeRdData, oExtRdData;
    logic          oCen, oWrEn;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] oWrData, oWrMask;
    logic [DW-1:0] iMemData;

    dsram_arbiter #(
        .CACHE_WIDTHE (6),
        .CACHE_DEEPTHE(AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk(clk), .rst(rst),
        .iPipeReq(iPipeReq), .iPipeWrEn(iPipeWrEn), .iPipeAddr(iPipeAddr),
        .iPipeWrData(iPipeWrData), .iPipeWrMask(iPipeWrMask),
        .oPipeGnt(oPipeGnt), .oPipeStall(oPipeStall),
        .oPipeRdValid(oPipeRdValid), .oPipeRdData(oPipeRdData),
        .iExtReq(iExtReq), .iExtWrEn(iExtWrEn), .iExtAddr(iExtAddr),
        .iExtWrData(iExtWrData), .iExtWrMask(iExtWrMask),
        .oExtGnt(oExtGnt), .oExtRdValid(oExtRdValid), .oExtRdData(oExtRdData),
        .oCen(oCen), .oWrEn(oWrEn), .oAddr(oAddr),
        .oWrData(oWrData), .oWrMask(oWrMask), .iMemData(iMemData)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return {32'hC0DE_0000 + 32'(i), ~(32'(i))};
    endfunction

    // SRAM model: masked bit writes, one-cycle registered read.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] mem_rd = '0;
    assign iMemData = mem_rd;
    always @(posedge clk) begin
        if (oCen) begin
            if (oWrEn) mem[oAddr] <= (mem[oAddr] & ~oWrMask) | (oWrData & oWrMask);
            else       mem_rd <= mem[oAddr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t pipe_q[$];
    exp_t ext_q[$];
    logic mon_en = 1'b0;

    // Monitor: pops the expected read return whenever a RdValid strobe appears.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (pipe_q.size() > 0 && pipe_q[0].cyc < cyc) begin
                e = pipe_q.pop_front();
                chk("pipe_rd_missing", 64'(0), 64'(1));
            end
            if (oPipeRdValid) begin
                if (pipe_q.size() == 0) chk("pipe_rd_unexpected", 64'(1), 64'(0));
                else begin
                    e = pipe_q.pop_front();
                    chk("pipe_rd_data", oPipeRdData, e.data);
                    chk("pipe_rd_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else chk("pipe_rd_idle_zero", oPipeRdData, 64'(0));
            if (ext_q.size() > 0 && ext_q[0].cyc < cyc) begin
                e = ext_q.pop_front();
                chk("ext_rd_missing", 64'(0), 64'(1));
            end
            if (oExtRdValid) begin
                if (ext_q.size() == 0) chk("ext_rd_unexpected", 64'(1), 64'(0));
                else begin
                    e = ext_q.pop_front();
                    chk("ext_rd_data", oExtRdData, e.data);
                    chk("ext_rd_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else chk("ext_rd_idle_zero", oExtRdData, 64'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
        iPipeReq = req; iPipeWrEn = we; iPipeAddr = a; iPipeWrData = d; iPipeWrMask = m;
    endtask

    task automatic ext(input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
        iExtReq = req; iExtWrEn = we; iExtAddr = a; iExtWrData = d; iExtWrMask = m;
    endtask

    // Waits to mid-cycle and checks the combinational grant outputs.
    task automatic gnt(input string tag, input logic pg, input logic eg, input logic stall);
        @(negedge clk);
        chk({tag, "_pipe_gnt"}, 64'(oPipeGnt), 64'(pg));
        chk({tag, "_ext_gnt"}, 64'(oExtGnt), 64'(eg));
        chk({tag, "_cen"}, 64'(oCen), 64'(pg | eg));
        chk({tag, "_stall"}, 64'(oPipeStall), 64'(stall));
    endtask

    task automatic push_pipe(input logic [DW-1:0] d);
        pipe_q.push_back('{data: d, cyc: cyc + 1});
    endtask

    task automatic push_ext(input logic [DW-1:0] d);
        ext_q.push_back('{data: d, cyc: cyc + 1});
    endtask

    localparam logic [DW-1:0] ONES = '1;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = pat(i);
        rst = 1'b1;
        pipe(1'b1, 1'b0, 6'd0, '0, '0);
        ext(1'b1, 1'b0, 6'd0, '0, '0);
        step();
        mon_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_cen", 64'(oCen), 64'(0));
            chk("rst_pipe_gnt", 64'(oPipeGnt), 64'(0));
            chk("rst_ext_gnt", 64'(oExtGnt), 64'(0));
            step();
        end

        // Pipeline wins first cycle after reset; held ext request follows.
        rst = 1'b0;
        gnt("post_rst", 1'b1, 1'b0, 1'b0); push_pipe(pat(0)); step();
        pipe(1'b0, 1'b0, 6'd0, '0, '0);
        gnt("ext_idle_pipe", 1'b0, 1'b1, 1'b0); push_ext(pat(0)); step();
        ext(1'b0, 1'b0, 6'd0, '0, '0);

        // Write then read back the same address.
        pipe(1'b1, 1'b1, 6'd5, 64'hDEAD_BEEF_0123_4567, ONES);
        gnt("wr5", 1'b1, 1'b0, 1'b0);
        chk("wr5_wren", 64'(oWrEn), 64'(1));
        chk("wr5_addr", 64'(oAddr), 64'(5));
        chk("wr5_data", oWrData, 64'hDEAD_BEEF_0123_4567);
        step();
        pipe(1'b1, 1'b0, 6'd5, '0, '0);
        gnt("rd5", 1'b1, 1'b0, 1'b0);
        chk("rd5_wren", 64'(oWrEn), 64'(0));
        push_pipe(64'hDEAD_BEEF_0123_4567); step();
        pipe(1'b0, 1'b0, 6'd0, '0, '0);
        gnt("idle", 1'b0, 1'b0, 1'b0);
        chk("idle_wren", 64'(oWrEn), 64'(0));
        chk("idle_addr", 64'(oAddr), 64'(0));
        chk("idle_wmask", oWrMask, 64'(0));
        step();

        // Masked write.
        pipe(1'b1, 1'b1, 6'd3, ONES, ONES);
        gnt("wr3_full", 1'b1, 1'b0, 1'b0); step();
        pipe(1'b1, 1'b1, 6'd3, 64'h0, 64'h0000_0000_FFFF_FFFF);
        gnt("wr3_mask", 1'b1, 1'b0, 1'b0);
        chk("wr3_mask_val", oWrMask, 64'h0000_0000_FFFF_FFFF);
        step();
        pipe(1'b1, 1'b0, 6'd3, '0, '0);
        gnt("rd3", 1'b1, 1'b0, 1'b0); push_pipe(64'hFFFF_FFFF_0000_0000); step();

        // Starvation: pipe reads every cycle, ext read addr 7 waits 4 cycles.
        ext(1'b1, 1'b0, 6'd7, '0, '0);
        for (int k = 0; k < 4; k++) begin
            pipe(1'b1, 1'b0, 6'(10 + k), '0, '0);
            gnt("starve_wait", 1'b1, 1'b0, 1'b0); push_pipe(pat(10 + k)); step();
        end
        pipe(1'b1, 1'b0, 6'd14, '0, '0);
        gnt("starve_force", 1'b0, 1'b1, 1'b1);
        chk("starve_force_addr", 64'(oAddr), 64'(7));
        push_ext(pat(7)); step();
        ext(1'b0, 1'b0, 6'd0, '0, '0);
        gnt("starve_resume", 1'b1, 1'b0, 1'b0); push_pipe(pat(14)); step();
        pipe(1'b0, 1'b0, 6'd0, '0, '0);
        step();

        // Interleaved reads on consecutive cycles.
        pipe(1'b1, 1'b0, 6'd1, '0, '0);
        gnt("il_pipe", 1'b1, 1'b0, 1'b0); push_pipe(pat(1)); step();
        pipe(1'b0, 1'b0, 6'd0, '0, '0);
        ext(1'b1, 1'b0, 6'd2, '0, '0);
        gnt("il_ext", 1'b0, 1'b1, 1'b0); push_ext(pat(2)); step();
        ext(1'b0, 1'b0, 6'd0, '0, '0);

        // Top address via ext write, pipe read back.
        ext(1'b1, 1'b1, 6'd63, 64'h0123_4567_89AB_CDEF, ONES);
        gnt("wr63", 1'b0, 1'b1, 1'b0);
        chk("wr63_addr", 64'(oAddr), 64'(63));
        step();
        ext(1'b0, 1'b0, 6'd0, '0, '0);
        pipe(1'b1, 1'b0, 6'd63, '0, '0);
        gnt("rd63", 1'b1, 1'b0, 1'b0); push_pipe(64'h0123_4567_89AB_CDEF); step();

        // Read granted just before reset still returns during reset.
        pipe(1'b1, 1'b0, 6'd1, '0, '0);
        gnt("pre_rst_rd", 1'b1, 1'b0, 1'b0); push_pipe(pat(1)); step();
        rst = 1'b1;
        pipe(1'b1, 1'b0, 6'd2, '0, '0);
        ext(1'b1, 1'b0, 6'd2, '0, '0);
        gnt("in_rst", 1'b0, 1'b0, 1'b1); step();
        pipe(1'b0, 1'b0, 6'd0, '0, '0);
        ext(1'b0, 1'b0, 6'd0, '0, '0);
        gnt("in_rst2", 1'b0, 1'b0, 1'b0); step();
        rst = 1'b0;
        repeat (3) begin
            gnt("post_rst_idle", 1'b0, 1'b0, 1'b0); step();
        end

        @(negedge clk);
        mon_en = 1'b0;
        chk("pipe_q_drained", 64'(pipe_q.size()), 64'(0));
        chk("ext_q_drained", 64'(ext_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
